// File: rtl/imem_port_arb.sv
// rtl/imem_port_arb.sv - fetch/loader arbiter for a single-port instruction memory
// Optional macro IMEM_ARB_FAIR_EN bounds consecutive loader grants while fetch waits.
module imem_port_arb #(
    parameter int MAX_GRANT = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t             r_state;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_p1_err;
    logic               r_f_rvalid;
    logic               r_f_err;

    logic               w_fetch_due;
    logic               w_f_gnt;
    logic               w_l_gnt;
    logic               w_f_misal;

`ifdef IMEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(MAX_GRANT) + 1;
    logic [CNT_W-1:0]   r_starve;

    assign w_fetch_due = f_req && (r_starve == CNT_W'(MAX_GRANT));
`else
    assign w_fetch_due = 1'b0;
`endif

    // Loader wins ties unless the fetch side has waited out its allowance.
    assign w_l_gnt   = rst && l_req && !w_fetch_due;
    assign w_f_gnt   = rst && f_req && !w_l_gnt;
    assign w_f_misal = (f_addr & ~WORD_MASK) != '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_p1_err    <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_f_err     <= 1'b0;
        end else begin
            r_mem_en <= w_l_gnt || (w_f_gnt && !w_f_misal);
            r_mem_we <= w_l_gnt;
            if (w_l_gnt) begin
                r_mem_addr  <= l_addr & WORD_MASK;
                r_mem_wdata <= l_wdata;
            end else if (w_f_gnt) begin
                r_mem_addr  <= f_addr & WORD_MASK;
            end

            if (w_l_gnt)
                r_state <= S_LOAD;
            else if (w_f_gnt)
                r_state <= S_FETCH;
            else
                r_state <= S_IDLE;

            // S_FETCH doubles as the first stage of the read-return pipeline.
            r_p1_err   <= w_f_gnt && w_f_misal;
            r_f_rvalid <= (r_state == S_FETCH);
            r_f_err    <= (r_state == S_FETCH) && r_p1_err;
        end
    end

`ifdef IMEM_ARB_FAIR_EN
    always_ff @(posedge clk) begin
        if (!rst)
            r_starve <= '0;
        else if (w_l_gnt && f_req)
            r_starve <= r_starve + 1'b1;
        else
            r_starve <= '0;
    end
`endif

    assign f_gnt     = w_f_gnt;
    assign l_gnt     = w_l_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign f_rvalid  = r_f_rvalid;
    assign f_err     = r_f_err;
    assign f_rdata   = (r_f_rvalid && !r_f_err) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_port_arb.sv
// tb/tb_imem_port_arb.sv - scoreboard bench for imem_port_arb
module tb_imem_port_arb;

    localparam int MAX_GRANT = 4;
    localparam int ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_err;
    logic              l_req = 1'b0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [31:0]       l_wdata = '0;
    logic              l_gnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    imem_port_arb #(.MAX_GRANT(MAX_GRANT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } rd_t;

    cmd_t        cmd_q[$];
    rd_t         rd_q[$];
    cmd_t        mon_c;
    rd_t         mon_r;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          starve = 0;
    logic [31:0] tb_mem  [16];
    logic [31:0] ref_mem [16];
    logic        obs_f = 1'b0;
    logic        obs_l = 1'b0;
    logic        exp_f;
    logic        exp_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: read data is only meaningful the cycle after a read.
    always @(posedge clk) begin
        if (mem_en && mem_we)
            tb_mem[mem_addr[5:2]] <= mem_wdata;
        else if (mem_en)
            mem_rdata <= tb_mem[mem_addr[5:2]];
        else
            mem_rdata <= $urandom;
    end

    // Reference model: predicts grants and enqueues the memory command and read return.
    always @(negedge clk) begin
        obs_f = f_gnt;
        obs_l = l_gnt;
        exp_f = 1'b0;
        exp_l = 1'b0;
        if (!rst) begin
            starve = 0;
            while (cmd_q.size() > 0 && cmd_q[$].cyc > cyc) void'(cmd_q.pop_back());
            while (rd_q.size() > 0 && rd_q[$].cyc > cyc) void'(rd_q.pop_back());
        end else begin
            exp_l = l_req;
            exp_f = f_req && !l_req;
`ifdef IMEM_ARB_FAIR_EN
            if (f_req && l_req && starve == MAX_GRANT) begin
                exp_l = 1'b0;
                exp_f = 1'b1;
            end
            if (exp_l && f_req) starve++;
            else starve = 0;
`endif
            if (exp_l) begin
                cmd_q.push_back('{cyc + 1, 1'b1, l_addr & 32'hFFFF_FFFC, l_wdata});
                ref_mem[l_addr[5:2]] = l_wdata;
            end
            if (exp_f) begin
                if (f_addr[1:0] != 2'b00) begin
                    rd_q.push_back('{cyc + 2, 1'b1, 32'h0});
                end else begin
                    cmd_q.push_back('{cyc + 1, 1'b0, f_addr, 32'h0});
                    rd_q.push_back('{cyc + 2, 1'b0, ref_mem[f_addr[5:2]]});
                end
            end
        end
        check("f_gnt", {31'h0, f_gnt}, {31'h0, exp_f});
        check("l_gnt", {31'h0, l_gnt}, {31'h0, exp_l});
    end

    // Monitor: compares DUT outputs against whatever the model scheduled for this cycle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                mon_c = cmd_q.pop_front();
                check("mem_en", {31'h0, mem_en}, 32'h1);
                check("mem_we", {31'h0, mem_we}, {31'h0, mon_c.we});
                check("mem_addr", mem_addr, mon_c.addr);
                if (mon_c.we) check("mem_wdata", mem_wdata, mon_c.wdata);
            end else begin
                check("mem_en idle", {31'h0, mem_en}, 32'h0);
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                mon_r = rd_q.pop_front();
                check("f_rvalid", {31'h0, f_rvalid}, 32'h1);
                check("f_err", {31'h0, f_err}, {31'h0, mon_r.err});
                check("f_rdata", f_rdata, mon_r.data);
            end else begin
                check("f_rvalid idle", {31'h0, f_rvalid}, 32'h0);
                check("f_err idle", {31'h0, f_err}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [1:0]  exp_pat;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        tb_mem[0]  = 32'h00500093;
        ref_mem[0] = 32'h00500093;

        rst = 1'b0;
        tick();
        tick();
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst f_rdata", f_rdata, 32'h0);

        // First fetch right out of reset.
        rst = 1'b1;
        f_req = 1'b1;
        f_addr = 32'h0;
        tick();
        check("first fetch grant", {31'h0, obs_f}, 32'h1);
        f_req = 1'b0;
        check("fetch cmd mem_addr", mem_addr, 32'h0);
        tick();
        check("fetch f_rdata", f_rdata, 32'h00500093);
        tick();

        // Loader write ignores address low bits.
        l_req = 1'b1;
        l_addr = 32'h13;
        l_wdata = 32'hDEADBEEF;
        tick();
        l_req = 1'b0;
        check("ld mem_we", {31'h0, mem_we}, 32'h1);
        check("ld mem_addr", mem_addr, 32'h10);
        check("ld mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();

        // Misaligned fetch.
        f_req = 1'b1;
        f_addr = 32'h6;
        tick();
        f_req = 1'b0;
        check("misal mem_en", {31'h0, mem_en}, 32'h0);
        tick();
        check("misal f_rvalid", {31'h0, f_rvalid}, 32'h1);
        check("misal f_err", {31'h0, f_err}, 32'h1);
        check("misal f_rdata", f_rdata, 32'h0);
        tick();

        // Contention: both requesters held for ten cycles.
        f_req = 1'b1;
        f_addr = 32'h4;
        l_req = 1'b1;
        l_addr = 32'h20;
        l_wdata = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            tick();
`ifdef IMEM_ARB_FAIR_EN
            exp_pat = (i % 5 == 4) ? 2'b10 : 2'b01;
`else
            exp_pat = 2'b01;
`endif
            check($sformatf("grant_pat[%0d]", i), {30'h0, obs_f, obs_l}, {30'h0, exp_pat});
        end
        f_req = 1'b0;
        l_req = 1'b0;
        tick();
        tick();
        tick();

        // Reset right after a fetch grant must squash its return.
        f_req = 1'b1;
        f_addr = 32'h8;
        tick();
        f_req = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Back-to-back fetches.
        f_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_addr = 32'(i * 4);
            tick();
            check($sformatf("b2b grant[%0d]", i), {31'h0, obs_f}, 32'h1);
        end
        f_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (!f_req || obs_f) begin
                f_req = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 7) == 0)
                    f_addr = 32'($urandom_range(0, 63));
                else
                    f_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!l_req || obs_l) begin
                l_req = ($urandom_range(0, 3) == 0);
                l_addr = 32'($urandom_range(0, 63));
                l_wdata = $urandom;
            end
            tick();
        end

        rst = 1'b1;
        f_req = 1'b0;
        l_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("cmd_q drained", 32'(cmd_q.size()), 32'h0);
        check("rd_q drained", 32'(rd_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arb.md
IMEM_PORT_ARB -- requirements
Module: imem_port_arb

Interface
REQ-001 Parameter: MAX_GRANT, default 4, consecutive loader grants allowed while fetch waits (fairness mode only).
REQ-002 Parameter: ADDR_W, default 32, byte-address width of all address ports.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 f_req  input  1  fetch read request; held with f_addr stable until f_gnt.
REQ-006 f_addr  input  ADDR_W  fetch byte address (PC).
REQ-007 f_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-008 f_rvalid  output  1  fetch read data valid (registered-timing).
REQ-009 f_rdata  output  32  instruction word returned.
REQ-010 f_err  output  1  qualifies f_rvalid; misaligned fetch.
REQ-011 l_req  input  1  loader write request; held with l_addr/l_wdata stable until l_gnt.
REQ-012 l_addr  input  ADDR_W  loader byte address.
REQ-013 l_wdata  input  32  loader write word, little-endian byte order.
REQ-014 l_gnt  output  1  loader request accepted this cycle (combinational).
REQ-015 mem_en, mem_we  output  1 each  registered memory command strobes.
REQ-016 mem_addr  output  ADDR_W  registered word-aligned memory address.
REQ-017 mem_wdata  output  32  registered write data.
REQ-018 mem_rdata  input  32  memory read data, valid exactly one cycle after a read command.

Function
REQ-019 Arbitration is evaluated every cycle; at most one of f_gnt/l_gnt asserted per cycle.
REQ-020 Request granted in cycle N SHALL drive mem_en=1 in cycle N+1 (mem_we=1 for loader, 0 for fetch); mem_en=0 in cycles with no grant in N.
REQ-021 Fetch granted in cycle N SHALL produce f_rvalid=1 for exactly one cycle in N+2, f_rdata=mem_rdata in that cycle.
REQ-022 Back-to-back grants permitted every cycle; read data returns in grant order, no bubbles inserted.
REQ-023 mem_addr SHALL equal granted address with bits [1:0] forced to 0.
REQ-024 Fetch with f_addr[1:0]!=0: granted normally, no memory command issued (mem_en=0 in N+1), f_rvalid=1, f_err=1, f_rdata=0 in N+2.
REQ-025 Loader address bits [1:0] ignored; no error path for loader.
REQ-026 Priority: both requesting -> loader granted, except as REQ-028.
REQ-027 State machine owner register: S_IDLE (no grant last cycle), S_FETCH (fetch granted last cycle), S_LOAD (loader granted last cycle); transition each cycle to the state matching this cycle's grant.
REQ-028 Starvation counter (width clog2(MAX_GRANT)+1): increments on each loader grant while f_req=1; clears on fetch grant or f_req=0; when equal to MAX_GRANT and f_req=1, fetch SHALL be granted over loader.
REQ-029 f_err=0 whenever f_rvalid=0.

Reset
REQ-030 rst=0 at a clock edge SHALL set: state S_IDLE, counter 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, in-flight read pipeline cleared.
REQ-031 f_gnt=0 and l_gnt=0 while rst=0; f_rvalid=0, f_err=0, f_rdata=0 from the cycle after reset is sampled.
REQ-032 Reset mid-operation: any fetch granted before reset SHALL NOT produce f_rvalid after reset release.
REQ-033 First grant possible in the first cycle with rst=1.

Configuration
REQ-034 Macro IMEM_ARB_FAIR_EN: defined -> REQ-028 fairness active; undefined -> strict loader priority, counter not implemented, fetch granted only when l_req=0.

Verification
REQ-035 Reset, f_req=1 f_addr=0x0, memory word 0x00500093 -> f_gnt cycle 1, mem_en=1/mem_we=0/mem_addr=0x0 cycle 2, f_rvalid=1 f_rdata=0x00500093 cycle 3.
REQ-036 l_req=1 l_addr=0x13 l_wdata=0xDEADBEEF -> l_gnt, next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF.
REQ-037 f_addr=0x6 -> f_rvalid=1, f_err=1, f_rdata=0, mem_en=0 in the intervening cycle.
REQ-038 l_req and f_req held 10 cycles, MAX_GRANT=4, IMEM_ARB_FAIR_EN defined -> grant pattern L,L,L,L,F,L,L,L,L,F; undefined -> 10 loader grants, no f_gnt.
REQ-039 f_req granted, rst=0 the next cycle for one cycle -> no f_rvalid in any later cycle; mem_en=0 after reset.
REQ-040 Fetch addresses 0x0,0x4,0x8 granted in consecutive cycles -> three consecutive f_rvalid cycles, data in address order.
